// File: rtl/img_write.sv
// img_write: captures one windowed video frame into block RAM and offers registered readback.
// Build macro IMG_WRITE_THRESH_EN stores 8'hFF/8'h00 (pix_in >= THRESH) instead of raw pixels.
module img_write #(
    parameter int WIDTH   = 120,
    parameter int HEIGTH  = 90,
    parameter int H_START = 50,
    parameter int V_START = 29,
    parameter int THRESH  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        short_frame,
    input  logic [13:0] rd_addr,
    output logic [7:0]  rd_data
);

    localparam int          DEPTH     = WIDTH * HEIGTH;
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);
    localparam logic [9:0]  CNT_MAX   = 10'h3FF;
    localparam logic [9:0]  V0        = 10'(V_START);
    localparam logic [9:0]  H0        = 10'(H_START);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]  state;
    logic        hs_q, hs_p, vs_q, vs_p;
    logic        hs_rise, vs_rise;
    logic [9:0]  lcnt, pcnt;
    logic        pphase;
    logic [9:0]  row, col;
    logic        in_win;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic        we, last_wr;
    logic [7:0]  mem [DEPTH];

    // History resets high so a sync already idling high never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= 1'b1;
            hs_p <= 1'b1;
            vs_q <= 1'b1;
            vs_p <= 1'b1;
        end else begin
            hs_q <= hsync;
            hs_p <= hs_q;
            vs_q <= vsync;
            vs_p <= vs_q;
        end
    end

    assign hs_rise = hs_q & ~hs_p;
    assign vs_rise = vs_q & ~vs_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt   <= '0;
            pcnt   <= '0;
            pphase <= 1'b0;
        end else begin
            if (vs_rise)
                lcnt <= '0;
            else if (hs_rise && lcnt != CNT_MAX)
                lcnt <= lcnt + 10'd1;

            if (hs_rise) begin
                pcnt   <= '0;
                pphase <= 1'b0;
            end else begin
                pphase <= ~pphase;
                if (pphase && pcnt != CNT_MAX)
                    pcnt <= pcnt + 10'd1;
            end
        end
    end

    // The lower-bound checks keep the wrapped subtraction from aliasing into the window.
    assign row     = lcnt - V0;
    assign col     = pcnt - H0;
    assign in_win  = (lcnt >= V0) && (row < 10'(HEIGTH)) &&
                     (pcnt >= H0) && (col < 10'(WIDTH));
    assign wr_addr = {4'b0, row} * 14'(WIDTH) + {4'b0, col};

`ifdef IMG_WRITE_THRESH_EN
    assign wr_data = (pix_in >= 8'(THRESH)) ? 8'hFF : 8'h00;
`else
    assign wr_data = pix_in;
`endif

    assign we      = (state == CAPTURE) && in_win && !rst;
    assign last_wr = we && (wr_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ARM;
                        short_frame <= 1'b0;
                    end
                end
                ARM: begin
                    if (vs_rise)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    if (last_wr) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end else if (vs_rise) begin
                        short_frame <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == ARM) || (state == CAPTURE);

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr[AW-1:0]] <= wr_data;
    end

    // Read-before-write: a same-cycle write to rd_addr is seen on the following read.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if ({18'b0, rd_addr} < 32'(DEPTH))
            rd_data <= mem[rd_addr[AW-1:0]];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_img_write.sv
// Directed scoreboard bench for img_write on a scaled-down video timing (small window, short lines).
module tb_img_write;

    localparam int W      = 16;
    localparam int H      = 12;
    localparam int HS     = 4;
    localparam int VS     = 3;
    localparam int TH     = 64;
    localparam int DEPTH  = W * H;
    localparam int LINE   = 56;
    localparam int HS_LEN = 6;
    localparam int NL     = 20;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_ARM  = 2'd1;
    localparam logic [1:0] M_CAP  = 2'd2;

    logic        clk = 1'b0;
    logic        rst, hsync, vsync, start;
    logic [7:0]  pix_in;
    logic        busy, frame_done, short_frame;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;

    img_write #(
        .WIDTH  (W),
        .HEIGTH (H),
        .H_START(HS),
        .V_START(VS),
        .THRESH (TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .hsync      (hsync),
        .vsync      (vsync),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .short_frame(short_frame),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         n = 0;
    int         fd_seen = 0;
    int         fdb;
    int         fd_q[$];
    logic [7:0] rq[$];
    logic [7:0] mdl [DEPTH];
    logic [1:0] m_st = M_IDLE;
    logic       m_sf = 1'b0;
    logic       vs_last = 1'b1;
    logic       vs_pend = 1'b0;
    bit         chk_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h step=%0d", tag, obs, exp, n);
        end
    endtask

    function automatic logic [7:0] wr_val(input logic [7:0] p);
`ifdef IMG_WRITE_THRESH_EN
        return (p >= 8'(TH)) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    function automatic logic [7:0] pat(input int mode, input int a);
        case (mode)
            0:       return 8'(a);
            1:       return 8'(a % 100 + 1);
            default: return 8'(60 + a % 8);
        endcase
    endfunction

    // One input cycle: drive, advance the reference state, then check outputs at negedge.
    task automatic step(input logic h, input logic v, input logic [7:0] p, input logic s,
                        input logic r, input bit win, input int a);
        logic [7:0] exp_rd;
        logic       exp_fd;
        logic       vr;
        hsync = h; vsync = v; pix_in = p; start = s; rst = r;
        vr      = vs_pend;
        vs_pend = v && !vs_last;
        vs_last = v;
        exp_rd  = (int'(rd_addr) < DEPTH) ? mdl[int'(rd_addr)] : 8'h00;
        if (r) begin
            m_st = M_IDLE;
            m_sf = 1'b0;
        end else if (m_st == M_CAP && win) begin
            mdl[a] = wr_val(p);
            if (a == DEPTH - 1) begin
                m_st = M_IDLE;
                fd_q.push_back(n + 1);
            end else if (vr) begin
                m_sf = 1'b1;
            end
        end else begin
            case (m_st)
                M_IDLE: if (s) begin m_st = M_ARM; m_sf = 1'b0; end
                M_ARM:  if (vr) m_st = M_CAP;
                M_CAP:  if (vr) m_sf = 1'b1;
                default: ;
            endcase
        end
        @(posedge clk);
        n++;
        @(negedge clk);
        chk("busy", busy, m_st != M_IDLE);
        chk("short_frame", short_frame, m_sf);
        if (chk_rd) chk("rd_same_cycle", rd_data, exp_rd);
        exp_fd = 1'b0;
        if (fd_q.size() > 0) begin
            if (fd_q[0] == n) begin
                exp_fd = 1'b1;
                void'(fd_q.pop_front());
            end
        end
        chk("frame_done", frame_done, exp_fd);
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic frame(input int nl, input int mode, input int start_line, input int rst_line);
        for (int ln = 0; ln < nl; ln++) begin
            for (int k = 0; k < LINE; k++) begin
                int pc;
                int a;
                bit win;
                pc  = (k - 2) / 2;
                win = (ln >= VS) && (ln - VS < H) && (k >= 2) && (pc >= HS) && (pc - HS < W);
                a   = win ? (ln - VS) * W + (pc - HS) : 0;
                step(k < LINE - HS_LEN, ln < nl - 2, win ? pat(mode, a) : 8'hAA,
                     ln == start_line && k == 10, ln == rst_line && k == 8, win, a);
            end
        end
    endtask

    task automatic readback(input bit no_aa);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 14'(a);
            rq.push_back(mdl[a]);
            @(posedge clk);
            n++;
            @(negedge clk);
            chk("readback", rd_data, rq.pop_front());
            if (no_aa) chk("no_aa", rd_data != 8'hAA, 1'b1);
        end
    endtask

    task automatic read1(input string tag, input logic [13:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        @(posedge clk);
        n++;
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; start = 1'b0; pix_in = 8'hAA; rd_addr = '0;
        repeat (3) step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_frame_done", frame_done, 1'b0);

        // Arm in one frame, capture the next; a start mid-capture must be ignored.
        frame(NL, 0, 5, -1);
        fdb = fd_seen;
        frame(NL, 0, 8, -1);
        chk("one_frame_done", fd_seen - fdb, 1);
        chk("fd_q_empty", fd_q.size(), 0);
        readback(1'b0);
        read1("addr121", 14'd121, wr_val(8'h79));
        read1("oob_depth", 14'(DEPTH), 8'h00);
        read1("oob_max", 14'h3FFF, 8'h00);

        // Out-of-window samples are 8'hAA and must never land in memory.
        frame(NL, 1, 5, -1);
        fdb = fd_seen;
        frame(NL, 1, -1, -1);
        chk("one_frame_done_b", fd_seen - fdb, 1);
        readback(1'b1);

        // Early vsync at row 6 restarts the capture and latches short_frame.
        frame(NL, 0, 5, -1);
        fdb = fd_seen;
        frame(VS + 6, 0, -1, -1);
        chk("short_before", short_frame, 1'b0);
        frame(NL, 0, -1, -1);
        chk("short_frame_done", fd_seen - fdb, 1);
        chk("short_sticky", short_frame, 1'b1);
        frame(NL, 1, 5, -1);
        chk("short_cleared", short_frame, 1'b0);

        // Hold rd_addr on a location written during this capture.
        rd_addr = 14'd100;
        chk_rd = 1'b1;
        fdb = fd_seen;
        frame(NL, 1, -1, -1);
        chk_rd = 1'b0;
        chk("rdwr_frame_done", fd_seen - fdb, 1);
        read1("rdwr_new", 14'd100, wr_val(8'd1));

        frame(NL, 2, 5, -1);
        fdb = fd_seen;
        frame(NL, 2, -1, -1);
        chk("thr_frame_done", fd_seen - fdb, 1);
        readback(1'b0);
`ifdef IMG_WRITE_THRESH_EN
        read1("thr63", 14'd3, 8'h00);
        read1("thr64", 14'd4, 8'hFF);
`else
        read1("thr63", 14'd3, 8'h3F);
        read1("thr64", 14'd4, 8'h40);
`endif

        // Reset at row 8 aborts the capture without a frame_done.
        frame(NL, 0, 5, -1);
        fdb = fd_seen;
        frame(NL, 0, -1, VS + 8);
        chk("rst_abort_no_done", fd_seen - fdb, 0);
        chk("rst_abort_busy", busy, 1'b0);
        chk("fd_q_empty_end", fd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
